// File: rtl/fir_secuenciador_pkg.sv
// Shared constants for the FIR sequencer: default widths/latency and FSM state encoding.
package fir_secuenciador_pkg;

    localparam int unsigned NDef    = 16;
    localparam int unsigned TapsDef = 4;
    localparam int unsigned LatDef  = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } estado_e;

    // Index width that stays at least one bit wide when the bank has a single entry.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_secuenciador_banco_coef.sv
// Coefficient register file: synchronous write, combinational read, synchronous clear.
module banco_coef
    import fir_secuenciador_pkg::*;
#(
    parameter int unsigned N    = NDef,
    parameter int unsigned TAPS = TapsDef,
    parameter int unsigned AW   = idx_width(TAPS)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [N-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [N-1:0]  rdata_o
);

    logic [N-1:0] mem_q [TAPS];
    logic [N-1:0] mem_d [TAPS];
    logic         we_ok;

    assign we_ok = we_i && (32'(waddr_i) < TAPS);

    always_comb begin
        mem_d = mem_q;
        if (we_ok) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // A write in the same cycle as the read is forwarded, so a start that coincides with
    // a coefficient update already issues the new value.
    always_comb begin
        rdata_o = mem_q[raddr_i];
        if (we_ok && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fir_secuenciador.sv
// FIR sequencer: delay line plus tap-by-tap issue of (coef, sample, partial sum) to a
// downstream multiply-add unit, with the final sum presented on salida/valido.
module fir_secuenciador
    import fir_secuenciador_pkg::*;
#(
    parameter int unsigned N    = NDef,
    parameter int unsigned TAPS = TapsDef,
    parameter int unsigned LAT  = LatDef,
    localparam int unsigned AW  = idx_width(TAPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  muestra,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [N-1:0]  coef_data,
    input  logic [N-1:0]  resultado_in,
    output logic [N-1:0]  dato1,
    output logic [N-1:0]  dato2,
    output logic [N-1:0]  dato3,
    output logic [N-1:0]  salida,
    output logic          valido,
    output logic          busy
);

    localparam int unsigned   CW      = $clog2(LAT + 1);
    localparam logic [AW-1:0] KLast   = AW'(TAPS - 1);
    localparam logic [CW-1:0] CntLoad = CW'(LAT);

    estado_e       state_q, state_d;
    logic [AW-1:0] k_q, k_d, rd_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  x_q [TAPS];
    logic [N-1:0]  x_d [TAPS];
    logic [N-1:0]  dato1_q, dato1_d, dato2_q, dato2_d, dato3_q, dato3_d;
    logic [N-1:0]  salida_q, salida_d;
    logic          valido_q, valido_d;
    logic [N-1:0]  coef_rd;
    logic          coef_we_idle;

    assign coef_we_idle = coef_we && (state_q == StIdle);

    banco_coef #(
        .N    (N),
        .TAPS (TAPS),
        .AW   (AW)
    ) u_banco_coef (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (coef_we_idle),
        .waddr_i (coef_addr),
        .wdata_i (coef_data),
        .raddr_i (rd_idx),
        .rdata_o (coef_rd)
    );

    // Operand registers are loaded on the edge entering ISSUE, so the tap's operands are
    // visible during the ISSUE cycle itself. The partial sum is forwarded straight from
    // resultado_in rather than through a separate accumulator register.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        dato1_d  = '0;
        dato2_d  = '0;
        dato3_d  = '0;
        salida_d = salida_q;
        valido_d = 1'b0;
        rd_idx   = (state_q == StIdle) ? '0 : k_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int unsigned i = 1; i < TAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0]  = muestra;
                    k_d     = '0;
                    dato1_d = coef_rd;
                    dato2_d = muestra;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CntLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == CW'(1)) begin
                    if (k_q == KLast) begin
                        salida_d = resultado_in;
                        valido_d = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        k_d     = rd_idx;
                        dato1_d = coef_rd;
                        dato2_d = x_q[rd_idx];
                        dato3_d = resultado_in;
                        state_d = StIssue;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            cnt_q    <= '0;
            dato1_q  <= '0;
            dato2_q  <= '0;
            dato3_q  <= '0;
            salida_q <= '0;
            valido_q <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            dato1_q  <= dato1_d;
            dato2_q  <= dato2_d;
            dato3_q  <= dato3_d;
            salida_q <= salida_d;
            valido_q <= valido_d;
            x_q      <= x_d;
        end
    end

    assign dato1  = dato1_q;
    assign dato2  = dato2_q;
    assign dato3  = dato3_q;
    assign salida = salida_q;
    assign valido = valido_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_fir_secuenciador.sv
// Bench for fir_secuenciador: table vectors, corner sequences and random back-to-back samples.
module tb_fir_secuenciador;

    localparam int unsigned N    = 16;
    localparam int unsigned TAPS = 4;
    localparam int unsigned LAT  = 4;
    localparam int unsigned VCYC = TAPS * (LAT + 1) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, coef_we, valido, busy;
    logic [1:0]   coef_addr;
    logic [N-1:0] muestra, coef_data, res_in, dato1, dato2, dato3, salida;

    logic         start1, coef_we1, valido1, busy1;
    logic [0:0]   coef_addr1;
    logic [N-1:0] muestra1, coef_data1, res_in1, d1_1, d2_1, d3_1, salida1;

    fir_secuenciador #(.N(N), .TAPS(TAPS), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .muestra(muestra), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .resultado_in(res_in),
        .dato1(dato1), .dato2(dato2), .dato3(dato3), .salida(salida), .valido(valido),
        .busy(busy)
    );

    fir_secuenciador #(.N(N), .TAPS(1), .LAT(LAT)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .muestra(muestra1), .coef_we(coef_we1),
        .coef_addr(coef_addr1), .coef_data(coef_data1), .resultado_in(res_in1),
        .dato1(d1_1), .dato2(d2_1), .dato3(d3_1), .salida(salida1), .valido(valido1),
        .busy(busy1)
    );

    // Stub multiply-add units: low N bits of d1*d2+d3, LAT cycles later.
    logic [N-1:0] pipe [LAT];
    logic [N-1:0] pipe1 [LAT];
    always @(posedge clk) begin
        pipe[0]  <= N'(dato1 * dato2 + dato3);
        pipe1[0] <= N'(d1_1 * d2_1 + d3_1);
        for (int i = 1; i < LAT; i++) begin
            pipe[i]  <= pipe[i-1];
            pipe1[i] <= pipe1[i-1];
        end
    end
    assign res_in  = pipe[LAT-1];
    assign res_in1 = pipe1[LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain FIR sum over the sample history.
    logic [N-1:0] m_coef [TAPS];
    logic [N-1:0] m_x [TAPS];

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = '0;
            m_x[i]    = '0;
        end
    endtask

    task automatic model_shift(input logic [N-1:0] s);
        for (int i = TAPS - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = s;
    endtask

    function automatic logic [N-1:0] model_fir();
        logic [31:0] acc = 0;
        for (int i = 0; i < TAPS; i++) acc = acc + m_coef[i] * m_x[i];
        return acc[N-1:0];
    endfunction

    task automatic write_coef(input int a, input logic [N-1:0] d);
        coef_we   = 1'b1;
        coef_addr = 2'(a);
        coef_data = d;
        m_coef[a] = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Starts a sample in the current cycle and returns in the valido cycle.
    task automatic do_sample(input logic [N-1:0] s, input logic [N-1:0] exp, input bit noisy,
                             input bit wr, input logic [1:0] wa, input logic [N-1:0] wd,
                             input string tag);
        int cyc;
        start     = 1'b1;
        muestra   = s;
        coef_we   = wr;
        coef_addr = wa;
        coef_data = wd;
        @(negedge clk);
        cyc     = 1;
        start   = 1'b0;
        coef_we = 1'b0;
        muestra = N'($urandom);
        check({tag, "_busy"}, 32'(busy), 1);
        while (!valido && cyc < 40) begin
            start     = noisy && (cyc == 3 || cyc == 10);
            coef_we   = noisy && (cyc == 7);
            coef_addr = 2'd0;
            coef_data = 16'h0055;
            @(negedge clk);
            cyc++;
        end
        start   = 1'b0;
        coef_we = 1'b0;
        check({tag, "_valido_cycle"}, 32'(cyc), VCYC);
        check({tag, "_salida"}, 32'(salida), 32'(exp));
    endtask

    typedef struct {
        bit           load;
        logic [N-1:0] c0, c1, c2, c3;
        logic [N-1:0] samp;
        logic [N-1:0] exp;
        bit           noisy;
    } vec_t;

    function automatic vec_t mk(input bit load, input int c0, input int c1, input int c2,
                                input int c3, input int s, input int e, input bit noisy);
        vec_t v;
        v.load = load; v.c0 = N'(c0); v.c1 = N'(c1); v.c2 = N'(c2); v.c3 = N'(c3);
        v.samp = N'(s); v.exp = N'(e); v.noisy = noisy;
        return v;
    endfunction

    vec_t tbl [7];

    initial begin
        logic [N-1:0] e;
        int           cnt, cyc;

        tbl[0] = mk(1, 1, 2, 3, 4, 5, 5, 0);
        tbl[1] = mk(0, 0, 0, 0, 0, 6, 16, 0);
        tbl[2] = mk(1, 1, 1, 1, 1, 7, 18, 1);
        tbl[3] = mk(0, 0, 0, 0, 0, 1, 19, 0);
        tbl[4] = mk(1, 0, 0, 0, 1, 9, 6, 0);
        tbl[5] = mk(1, 'hFFFF, 2, 0, 0, 3, 15, 0);
        tbl[6] = mk(1, 'h100, 'h100, 0, 0, 'h100, 'h300, 0);

        reset = 1'b1; start = 1'b0; coef_we = 1'b0; coef_addr = '0; muestra = '0;
        coef_data = '0; start1 = 1'b0; coef_we1 = 1'b0; coef_addr1 = '0; muestra1 = '0;
        coef_data1 = '0;
        model_reset();
        repeat (6) @(negedge clk);
        check("rst_dato1", 32'(dato1), 0);
        check("rst_dato2", 32'(dato2), 0);
        check("rst_dato3", 32'(dato3), 0);
        check("rst_salida", 32'(salida), 0);
        check("rst_valido", 32'(valido), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].load) begin
                write_coef(0, tbl[i].c0);
                write_coef(1, tbl[i].c1);
                write_coef(2, tbl[i].c2);
                write_coef(3, tbl[i].c3);
            end
            model_shift(tbl[i].samp);
            do_sample(tbl[i].samp, tbl[i].exp, tbl[i].noisy, 1'b0, 2'd0, '0,
                      $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d_single_strobe", i), 32'(valido), 0);
            check($sformatf("vec%0d_salida_hold", i), 32'(salida), 32'(tbl[i].exp));
        end

        // Coefficient write in the same cycle as start must be used by tap 0.
        m_coef[0] = 16'd10;
        model_shift(16'd2);
        do_sample(16'd2, model_fir(), 1'b0, 1'b1, 2'd0, 16'd10, "wr_with_start");
        @(negedge clk);

        // Reset during the WAIT of tap 2.
        write_coef(0, 16'd1); write_coef(1, 16'd2); write_coef(2, 16'd3); write_coef(3, 16'd4);
        start = 1'b1; muestra = 16'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("midrst_dato1", 32'(dato1), 0);
        check("midrst_dato2", 32'(dato2), 0);
        check("midrst_dato3", 32'(dato3), 0);
        check("midrst_salida", 32'(salida), 0);
        check("midrst_valido", 32'(valido), 0);
        check("midrst_busy", 32'(busy), 0);
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (valido) cnt++;
        end
        check("midrst_no_valido", 32'(cnt), 0);
        write_coef(0, 16'd1); write_coef(1, 16'd2); write_coef(2, 16'd3); write_coef(3, 16'd4);
        model_shift(16'd7);
        do_sample(16'd7, 16'd7, 1'b0, 1'b0, 2'd0, '0, "after_rst");

        // Random samples started back-to-back in each valido cycle.
        for (int i = 0; i < 10; i++) begin
            bit           wr = 1'($urandom);
            logic [1:0]   wa = 2'($urandom);
            logic [N-1:0] wd = N'($urandom);
            logic [N-1:0] s  = N'($urandom);
            if (wr) m_coef[wa] = wd;
            model_shift(s);
            e = model_fir();
            do_sample(s, e, 1'b0, wr, wa, wd, $sformatf("rnd%0d", i));
        end
        @(negedge clk);
        check("rnd_single_strobe", 32'(valido), 0);

        // Single-tap instance: coef 3, samples 5 then 7.
        for (int i = 0; i < 2; i++) begin
            coef_we1   = (i == 0);
            coef_addr1 = 1'b0;
            coef_data1 = 16'd3;
            start1     = 1'b1;
            muestra1   = (i == 0) ? 16'd5 : 16'd7;
            @(negedge clk);
            cyc = 1; start1 = 1'b0; coef_we1 = 1'b0;
            check($sformatf("t1_%0d_busy", i), 32'(busy1), 1);
            while (!valido1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("t1_%0d_valido_cycle", i), 32'(cyc), LAT + 2);
            check($sformatf("t1_%0d_salida", i), 32'(salida1), (i == 0) ? 15 : 21);
            @(negedge clk);
            check($sformatf("t1_%0d_single_strobe", i), 32'(valido1), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
